uart_cmd_parser: RTL and testbench



---
 rtl/uart_cmd_pkg.sv | 18 +
 rtl/uart_cmd_timeout.sv | 38 +++
 rtl/uart_cmd_parser.sv | 180 ++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the framed UART command parser and its consumers.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPC,
        ST_LEN,
        ST_PAY,
        ST_CHK
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hAA;

    localparam logic [7:0] OP_DRIVE = 8'h01;
    localparam logic [7:0] OP_STOP  = 8'h02;
    localparam logic [7:0] OP_PING  = 8'h7F;

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte gap counter: clears on clr_i, counts while en_i, holds at the last count.
// expired_o is combinational from the count, so the parent sees expiry in the same cycle.
module uart_cmd_timeout #(
    parameter int TIMEOUT_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_cmd_parser.sv
// Decodes SYNC/OPC/LEN/PAYLOAD/CHK frames from a byte strobe; good frames load a valid/ready
// holding register one cycle after the CHK byte, and a busy register drops the frame with err_overflow.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter int         MAX_LEN        = 4,
    parameter int         TIMEOUT_CYCLES = 250000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_valid_i,
    input  logic [7:0]           rx_data_i,
    output logic                 cmd_valid_o,
    input  logic                 cmd_ready_i,
    output logic [7:0]           cmd_opcode_o,
    output logic [3:0]           cmd_len_o,
    output logic [8*MAX_LEN-1:0] cmd_payload_o,
    output logic                 err_checksum_o,
    output logic                 err_len_o,
    output logic                 err_timeout_o,
    output logic                 err_overflow_o
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t               state_q, state_d;
    logic [7:0]           sum_q, sum_d;
    logic [3:0]           idx_q, idx_d;
    logic [3:0]           len_q, len_d;
    logic [7:0]           opc_q, opc_d;
    logic [8*MAX_LEN-1:0] buf_q, buf_d;

    logic                 cmd_valid_q, cmd_valid_d;
    logic [7:0]           cmd_opcode_q, cmd_opcode_d;
    logic [3:0]           cmd_len_q, cmd_len_d;
    logic [8*MAX_LEN-1:0] cmd_payload_q, cmd_payload_d;

    logic err_checksum_q, err_checksum_d;
    logic err_len_q, err_len_d;
    logic err_timeout_q, err_timeout_d;
    logic err_overflow_q, err_overflow_d;

    logic       tmo_expired;
    logic [7:0] chk_sum;

    assign chk_sum = sum_q + rx_data_i;

    uart_cmd_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (rx_valid_i || (state_q == ST_IDLE)),
        .en_i     (state_q != ST_IDLE),
        .expired_o(tmo_expired)
    );

    always_comb begin
        state_d        = state_q;
        sum_d          = sum_q;
        idx_d          = idx_q;
        len_d          = len_q;
        opc_d          = opc_q;
        buf_d          = buf_q;
        cmd_valid_d    = cmd_valid_q;
        cmd_opcode_d   = cmd_opcode_q;
        cmd_len_d      = cmd_len_q;
        cmd_payload_d  = cmd_payload_q;
        err_checksum_d = 1'b0;
        err_len_d      = 1'b0;
        err_timeout_d  = 1'b0;
        err_overflow_d = 1'b0;

        if (cmd_valid_q && cmd_ready_i) begin
            cmd_valid_d = 1'b0;
        end

        if (rx_valid_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_data_i == SYNC_BYTE) begin
                        state_d = ST_OPC;
                        buf_d   = '0;
                    end
                end
                ST_OPC: begin
                    opc_d   = rx_data_i;
                    sum_d   = rx_data_i;
                    state_d = ST_LEN;
                end
                ST_LEN: begin
                    if (rx_data_i > MAX_LEN_B) begin
                        err_len_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        len_d   = rx_data_i[3:0];
                        sum_d   = sum_q + rx_data_i;
                        idx_d   = 4'd0;
                        state_d = (rx_data_i == 8'd0) ? ST_CHK : ST_PAY;
                    end
                end
                ST_PAY: begin
                    for (int i = 0; i < MAX_LEN; i++) begin
                        if (idx_q == 4'(i)) begin
                            buf_d[8*i +: 8] = rx_data_i;
                        end
                    end
                    sum_d = sum_q + rx_data_i;
                    idx_d = idx_q + 4'd1;
                    if (idx_q == (len_q - 4'd1)) begin
                        state_d = ST_CHK;
                    end
                end
                ST_CHK: begin
                    state_d = ST_IDLE;
                    if (chk_sum != 8'd0) begin
                        err_checksum_d = 1'b1;
                    end else if (!cmd_valid_q || cmd_ready_i) begin
                        cmd_valid_d   = 1'b1;
                        cmd_opcode_d  = opc_q;
                        cmd_len_d     = len_q;
                        cmd_payload_d = buf_q;
                    end else begin
                        err_overflow_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (tmo_expired && (state_q != ST_IDLE)) begin
            // A byte landing on the expiry cycle takes the branch above instead.
            err_timeout_d = 1'b1;
            state_d       = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            sum_q          <= '0;
            idx_q          <= '0;
            len_q          <= '0;
            opc_q          <= '0;
            buf_q          <= '0;
            cmd_valid_q    <= 1'b0;
            cmd_opcode_q   <= '0;
            cmd_len_q      <= '0;
            cmd_payload_q  <= '0;
            err_checksum_q <= 1'b0;
            err_len_q      <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            sum_q          <= sum_d;
            idx_q          <= idx_d;
            len_q          <= len_d;
            opc_q          <= opc_d;
            buf_q          <= buf_d;
            cmd_valid_q    <= cmd_valid_d;
            cmd_opcode_q   <= cmd_opcode_d;
            cmd_len_q      <= cmd_len_d;
            cmd_payload_q  <= cmd_payload_d;
            err_checksum_q <= err_checksum_d;
            err_len_q      <= err_len_d;
            err_timeout_q  <= err_timeout_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    assign cmd_valid_o    = cmd_valid_q;
    assign cmd_opcode_o   = cmd_opcode_q;
    assign cmd_len_o      = cmd_len_q;
    assign cmd_payload_o  = cmd_payload_q;
    assign err_checksum_o = err_checksum_q;
    assign err_len_o      = err_len_q;
    assign err_timeout_o  = err_timeout_q;
    assign err_overflow_o = err_overflow_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: packet-level reference model plus directed and randomized byte streams.
module tb_uart_cmd_parser;
    import uart_cmd_pkg::*;

    localparam int MAX_LEN = 4;
    localparam int TMO     = 16;
    localparam int PW      = 8 * MAX_LEN;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          cmd_ready = 1'b0;
    logic          cmd_valid;
    logic [7:0]    cmd_opcode;
    logic [3:0]    cmd_len;
    logic [PW-1:0] cmd_payload;
    logic          err_checksum, err_len, err_timeout, err_overflow;

    uart_cmd_parser #(
        .SYNC_BYTE     (SYNC_BYTE_DEF),
        .MAX_LEN       (MAX_LEN),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_valid_i    (rx_valid),
        .rx_data_i     (rx_data),
        .cmd_valid_o   (cmd_valid),
        .cmd_ready_i   (cmd_ready),
        .cmd_opcode_o  (cmd_opcode),
        .cmd_len_o     (cmd_len),
        .cmd_payload_o (cmd_payload),
        .err_checksum_o(err_checksum),
        .err_len_o     (err_len),
        .err_timeout_o (err_timeout),
        .err_overflow_o(err_overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit started = 1'b0;
    bit rnd_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet-level model: bytes since SYNC kept in a queue, frame complete when size == LEN+3.
    bit            m_in = 1'b0;
    logic [7:0]    m_pk[$];
    int            m_gap = 0;
    bit            m_valid = 1'b0;
    logic [7:0]    m_opc = '0;
    logic [3:0]    m_len = '0;
    logic [PW-1:0] m_pay = '0;
    bit            m_e_chk = 1'b0, m_e_len = 1'b0, m_e_to = 1'b0, m_e_ovf = 1'b0;

    always @(posedge clk) begin
        bit            good, nv;
        int            n;
        logic [7:0]    s;
        logic [PW-1:0] p;
        if (rst) begin
            m_in = 1'b0; m_gap = 0; m_pk.delete();
            m_valid = 1'b0; m_opc = '0; m_len = '0; m_pay = '0;
            m_e_chk = 1'b0; m_e_len = 1'b0; m_e_to = 1'b0; m_e_ovf = 1'b0;
        end else begin
            good = 1'b0;
            m_e_chk = 1'b0; m_e_len = 1'b0; m_e_to = 1'b0; m_e_ovf = 1'b0;
            nv = m_valid && !cmd_ready;
            if (rx_valid) begin
                m_gap = 0;
                if (!m_in) begin
                    if (rx_data == SYNC_BYTE_DEF) begin
                        m_in = 1'b1;
                        m_pk.delete();
                    end
                end else begin
                    m_pk.push_back(rx_data);
                    n = m_pk.size();
                    if (n == 2 && int'(m_pk[1]) > MAX_LEN) begin
                        m_e_len = 1'b1;
                        m_in = 1'b0;
                    end else if (n >= 2 && n == int'(m_pk[1]) + 3) begin
                        m_in = 1'b0;
                        s = 8'd0;
                        foreach (m_pk[i]) s = s + m_pk[i];
                        if (s == 8'd0) good = 1'b1;
                        else m_e_chk = 1'b1;
                    end
                end
            end else if (m_in) begin
                m_gap++;
                if (m_gap >= TMO) begin
                    m_e_to = 1'b1;
                    m_in = 1'b0;
                end
            end
            if (good) begin
                if (!m_valid || cmd_ready) begin
                    nv = 1'b1;
                    m_opc = m_pk[0];
                    m_len = m_pk[1][3:0];
                    p = '0;
                    for (int i = 0; i < int'(m_pk[1]); i++) p[8*i +: 8] = m_pk[2+i];
                    m_pay = p;
                end else begin
                    m_e_ovf = 1'b1;
                end
            end
            m_valid = nv;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("cmd_valid", cmd_valid, m_valid);
            check("err_checksum", err_checksum, m_e_chk);
            check("err_len", err_len, m_e_len);
            check("err_timeout", err_timeout, m_e_to);
            check("err_overflow", err_overflow, m_e_ovf);
            if (m_valid) begin
                check("cmd_opcode", cmd_opcode, m_opc);
                check("cmd_len", cmd_len, m_len);
                check("cmd_payload", cmd_payload, m_pay);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            if (rnd_ready) cmd_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        if (rnd_ready) cmd_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    initial begin
        int         k_to;
        int         len;
        logic [7:0] q[$];
        logic [7:0] s, opc, b;

        repeat (2) @(negedge clk);
        started = 1'b1;
        check("rst_valid", cmd_valid, 1'b0);
        check("rst_opcode", cmd_opcode, 8'h00);
        check("rst_len", cmd_len, 4'h0);
        check("rst_payload", cmd_payload, 32'h0);
        check("rst_errs", {err_checksum, err_len, err_timeout, err_overflow}, 4'b0000);
        rst = 1'b0;
        cmd_ready = 1'b1;
        idle(2);

        send(8'hAA); send(OP_DRIVE); send(8'h02); send(8'h10); send(8'h20); send(8'hCD);
        check("p1_valid", cmd_valid, 1'b1);
        check("p1_opcode", cmd_opcode, 8'h01);
        check("p1_len", cmd_len, 4'd2);
        check("p1_payload", cmd_payload, 32'h0000_2010);
        check("p1_errs", {err_checksum, err_len, err_timeout, err_overflow}, 4'b0000);

        send(8'hAA); send(OP_STOP); send(8'h00); send(8'hFE);
        check("p2_valid", cmd_valid, 1'b1);
        check("p2_opcode", cmd_opcode, 8'h02);
        check("p2_payload", cmd_payload, 32'h0);
        send(8'hAA); send(OP_STOP); send(8'h00); send(8'hFF);
        check("bad_chk_err", err_checksum, 1'b1);
        check("bad_chk_valid", cmd_valid, 1'b0);

        send(8'h55); send(8'hAA); send(8'hAA); send(8'h00); send(8'h56);
        check("sync_data_valid", cmd_valid, 1'b1);
        check("sync_data_opcode", cmd_opcode, 8'hAA);

        send(8'hAA); send(OP_DRIVE); send(8'h05);
        check("len_err", err_len, 1'b1);
        send(8'hAA); send(OP_PING); send(8'h00); send(8'h81);
        check("after_len_opcode", cmd_opcode, 8'h7F);

        send(8'hAA); send(OP_DRIVE);
        k_to = 0;
        for (int k = 1; k <= 40; k++) begin
            idle(1);
            if (err_timeout) begin
                k_to = k;
                break;
            end
        end
        check("timeout_cycle", k_to, TMO);
        send(8'hAA); send(OP_STOP); send(8'h00); send(8'hFE);
        check("after_to_opcode", cmd_opcode, 8'h02);

        send(8'hAA); send(OP_DRIVE); idle(TMO - 1); send(8'h00); send(8'hFF);
        check("edge_byte_valid", cmd_valid, 1'b1);
        check("edge_byte_opcode", cmd_opcode, 8'h01);

        idle(2);
        cmd_ready = 1'b0;
        send(8'hAA); send(OP_DRIVE); send(8'h01); send(8'h33); send(8'hCB);
        check("held_payload", cmd_payload, 32'h0000_0033);
        send(8'hAA); send(OP_STOP); send(8'h00); send(8'hFE);
        check("ovf_err", err_overflow, 1'b1);
        check("ovf_held_opcode", cmd_opcode, 8'h01);
        send(8'hAA); send(OP_PING); send(8'h00);
        cmd_ready = 1'b1;
        send(8'h81);
        check("swap_valid", cmd_valid, 1'b1);
        check("swap_opcode", cmd_opcode, 8'h7F);

        rnd_ready = 1'b1;
        for (int p = 0; p < 200; p++) begin
            q.delete();
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            if ($urandom_range(0, 4) == 0) q.push_back(8'($urandom_range(0, 255)));
            len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(MAX_LEN + 1, 15))
                                              : int'($urandom_range(0, MAX_LEN));
            opc = 8'($urandom_range(0, 255));
            q.push_back(SYNC_BYTE_DEF);
            q.push_back(opc);
            q.push_back(8'(len));
            s = opc + 8'(len);
            for (int i = 0; i < len; i++) begin
                b = 8'($urandom_range(0, 255));
                q.push_back(b);
                s = s + b;
            end
            s = 8'd0 - s;
            if ($urandom_range(0, 7) == 0) s = s + 8'd1;
            q.push_back(s);
            foreach (q[i]) begin
                case ($urandom_range(0, 19))
                    0, 1, 2, 3:  idle(int'($urandom_range(1, 3)));
                    4:           idle(int'($urandom_range(TMO - 2, TMO + 2)));
                    default:     ;
                endcase
                send(q[i]);
            end
        end
        rnd_ready = 1'b0;
        cmd_ready = 1'b1;
        idle(TMO + 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
